// File: rtl/filter_pkg.sv
// filter_pkg: shared widths, one-hot output FSM encoding and saturation limits.
package filter_pkg;
  localparam int AUD_W = 16;
  localparam int STEREO_W = 2 * AUD_W;
  localparam int IDLE_ID = 0;
  localparam int SEND_ID = 1;
  localparam logic [1:0] IDLE = 2'b01;
  localparam logic [1:0] SEND = 2'b10;
  localparam logic [AUD_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [AUD_W-1:0] SAT_MIN = 16'h8000;
endpackage

// File: rtl/filter_out_fifo.sv
// filter_out_fifo: synchronous FIFO; a read on a full FIFO frees the slot for a same-cycle write.
module filter_out_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  parameter int PTR = 2
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         wren,
  input  logic [W-1:0] wrdata,
  input  logic         rden,
  output logic [W-1:0] rddata,
  output logic         full,
  output logic         empty,
  output logic [PTR:0] count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [PTR-1:0] r_wr, r_rd;
  logic [PTR:0] r_cnt;
  logic w_wr, w_rd;
  assign empty = r_cnt == '0;
  assign full = r_cnt == (PTR+1)'(DEPTH);
  assign w_rd = rden && !empty;
  assign w_wr = wren && (!full || w_rd);
  assign rddata = r_mem[r_rd];
  assign count = r_cnt;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      r_wr <= w_wr ? r_wr + PTR'(1) : r_wr;
      r_rd <= w_rd ? r_rd + PTR'(1) : r_rd;
      r_cnt <= r_cnt + {{PTR{1'b0}}, w_wr} - {{PTR{1'b0}}, w_rd};
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr] <= wrdata;
endmodule

// File: rtl/filter_out_stm.sv
// filter_out_stm: rounds/saturates stereo accumulator results, buffers them and
// sends {left,right} words over the rts/rtr handshake.
module filter_out_stm
  import filter_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4,
  parameter int PTR = 2
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  acc_done,
  input  logic [2*ACC_W-1:0]    acc_data,
  input  logic                  ovf_clear,
  input  logic                  aud_out_rtr,
  output logic                  aud_out_rts,
  output logic [STEREO_W-1:0]   aud_out,
  output logic                  sat_flag,
  output logic                  ovf_flag,
  output logic [PTR:0]          fifo_count
);
  localparam logic [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  // returns {saturated, 16-bit result}
  function automatic logic [AUD_W:0] rnd_sat(input logic [ACC_W-1:0] ch);
    logic signed [ACC_W:0] t;
    logic [ACC_W:0] s;
    t = signed'({ch[ACC_W-1], ch} + RND);
    s = t >>> SHIFT;
    if (&s[ACC_W:AUD_W-1] || ~|s[ACC_W:AUD_W-1]) return {1'b0, s[AUD_W-1:0]};
    return {1'b1, s[ACC_W] ? SAT_MIN : SAT_MAX};
  endfunction
  logic [AUD_W:0] w_l, w_r;
  logic r_s1_vld, r_s1_sat;
  logic [STEREO_W-1:0] r_s1_word, r_aud, w_rddata;
  logic [1:0] r_state, w_next;
  logic w_full, w_empty, w_xfer, w_pop, r_sat, r_ovf;
  assign w_l = rnd_sat(acc_data[2*ACC_W-1:ACC_W]);
  assign w_r = rnd_sat(acc_data[ACC_W-1:0]);
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      r_s1_vld <= 1'b0;
      r_s1_sat <= 1'b0;
      r_s1_word <= '0;
    end else begin
      r_s1_vld <= acc_done;
      r_s1_sat <= w_l[AUD_W] | w_r[AUD_W];
      r_s1_word <= {w_l[AUD_W-1:0], w_r[AUD_W-1:0]};
    end
  filter_out_fifo #(.W(STEREO_W), .DEPTH(DEPTH), .PTR(PTR)) u_fifo (
    .clk(clk), .rstb(rstb), .wren(r_s1_vld), .wrdata(r_s1_word), .rden(w_pop),
    .rddata(w_rddata), .full(w_full), .empty(w_empty), .count(fifo_count)
  );
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_xfer = r_state[SEND_ID] && aud_out_rtr;
    w_pop = !w_empty && (r_state[IDLE_ID] || w_xfer);
    w_next = w_pop ? SEND : (w_xfer ? IDLE : r_state);
  end
  assign aud_out_rts = r_state[SEND_ID];
  assign aud_out = r_aud;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) r_aud <= '0;
    else r_aud <= w_pop ? w_rddata : r_aud;
  // a new event in the same cycle as ovf_clear keeps the flag set
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      r_sat <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_sat <= (r_s1_vld && r_s1_sat) || (r_sat && !ovf_clear);
      r_ovf <= (r_s1_vld && w_full && !w_pop) || (r_ovf && !ovf_clear);
    end
  assign sat_flag = r_sat;
  assign ovf_flag = r_ovf;
endmodule

// File: tb/tb_filter_out_stm.sv
// tb_filter_out_stm: directed vector table, multi-cycle corner sequences and a random scoreboard run.
module tb_filter_out_stm;
  logic clk = 0, rstb = 0, acc_done = 0, ovf_clear = 0, aud_out_rtr = 0;
  logic [39:0] acc_data = '0;
  logic aud_out_rts, sat_flag, ovf_flag;
  logic [31:0] aud_out;
  logic [2:0] fifo_count;
  int checks = 0, errors = 0;

  filter_out_stm dut (
    .clk(clk), .rstb(rstb), .acc_done(acc_done), .acc_data(acc_data), .ovf_clear(ovf_clear),
    .aud_out_rtr(aud_out_rtr), .aud_out_rts(aud_out_rts), .aud_out(aud_out),
    .sat_flag(sat_flag), .ovf_flag(ovf_flag), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] l;
    logic [19:0] r;
    logic [31:0] word;
    logic sat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] mdl(input logic [19:0] c);
    int v;
    v = int'($signed(c)) + 8;
    v = (v < 0) ? -((-v + 15) / 16) : v / 16;
    if (v > 32767) return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  function automatic logic [31:0] kw(input int k);
    logic [15:0] a, b;
    a = 16'(k);
    b = 16'(-k);
    return {a, b};
  endfunction

  task automatic pulse_k(input int k);
    logic [19:0] a, b;
    a = 20'(k * 16);
    b = 20'(-k * 16);
    acc_data = {a, b};
    acc_done = 1;
    tick();
    acc_done = 0;
  endtask

  vec_t tbl[6];
  logic m_rts, m_s1v, m_s1s, m_sat, m_ovf, xfer, pop, push;
  logic [31:0] m_out, m_s1w;
  logic [31:0] q[$];
  logic [16:0] ml, mr;

  initial begin
    tbl[0] = '{20'h00018, 20'hFFFF8, 32'h0002_0000, 1'b0};
    tbl[1] = '{20'h7FFFF, 20'h80000, 32'h7FFF_8000, 1'b1};
    tbl[2] = '{20'h00017, 20'hFFFF7, 32'h0001_FFFF, 1'b0};
    tbl[3] = '{20'h7FFF7, 20'h80008, 32'h7FFF_8001, 1'b0};
    tbl[4] = '{20'h7FFF8, 20'h00000, 32'h7FFF_0000, 1'b1};
    tbl[5] = '{20'h00008, 20'hFFFF8, 32'h0001_0000, 1'b0};

    #2;
    chk("reset_rts", 32'(aud_out_rts), 0);
    chk("reset_aud", aud_out, 0);
    chk("reset_cnt", 32'(fifo_count), 0);
    chk("reset_flags", {30'd0, sat_flag, ovf_flag}, 0);
    tick();
    rstb = 1;
    tick();

    // rounding/saturation table, one sample at a time with rtr high
    aud_out_rtr = 1;
    foreach (tbl[i]) begin
      acc_data = {tbl[i].l, tbl[i].r};
      acc_done = 1;
      tick();
      acc_done = 0;
      chk("lat_rts_n1", 32'(aud_out_rts), 0);
      tick();
      chk("lat_rts_n2", 32'(aud_out_rts), 0);
      tick();
      chk("vec_rts", 32'(aud_out_rts), 1);
      chk("vec_word", aud_out, tbl[i].word);
      chk("vec_sat", 32'(sat_flag), 32'(tbl[i].sat));
      tick();
      chk("vec_rts_drop", 32'(aud_out_rts), 0);
      chk("vec_sat_sticky", 32'(sat_flag), 32'(tbl[i].sat));
      ovf_clear = 1;
      tick();
      ovf_clear = 0;
      chk("vec_sat_clr", 32'(sat_flag), 0);
    end

    // backpressure: six pulses, sixth dropped
    aud_out_rtr = 0;
    for (int k = 1; k <= 6; k++) pulse_k(k);
    tick();
    chk("bp_cnt", 32'(fifo_count), 4);
    chk("bp_ovf", 32'(ovf_flag), 1);
    chk("bp_rts", 32'(aud_out_rts), 1);
    chk("bp_hold", aud_out, kw(1));
    tick();
    chk("bp_hold2", aud_out, kw(1));
    aud_out_rtr = 1;
    for (int k = 1; k <= 5; k++) begin
      chk("bp_drain_rts", 32'(aud_out_rts), 1);
      chk("bp_drain_word", aud_out, kw(k));
      tick();
    end
    chk("bp_end_rts", 32'(aud_out_rts), 0);
    chk("bp_end_cnt", 32'(fifo_count), 0);
    ovf_clear = 1;
    tick();
    ovf_clear = 0;
    chk("ovf_clr", 32'(ovf_flag), 0);

    // full FIFO with push and pop in the same cycle
    aud_out_rtr = 0;
    for (int k = 11; k <= 15; k++) pulse_k(k);
    tick();
    chk("fp_cnt_full", 32'(fifo_count), 4);
    chk("fp_word_hold", aud_out, kw(11));
    pulse_k(16);
    aud_out_rtr = 1;
    tick();
    chk("fp_cnt", 32'(fifo_count), 4);
    chk("fp_ovf", 32'(ovf_flag), 0);
    for (int k = 12; k <= 16; k++) begin
      chk("fp_order", aud_out, kw(k));
      tick();
    end
    chk("fp_end_rts", 32'(aud_out_rts), 0);

    // reset mid-stream
    aud_out_rtr = 0;
    acc_data = {20'h7FFFF, 20'h00010};
    acc_done = 1;
    tick();
    acc_done = 0;
    for (int k = 22; k <= 24; k++) pulse_k(k);
    tick();
    chk("rs_pre_rts", 32'(aud_out_rts), 1);
    chk("rs_pre_cnt", 32'(fifo_count), 3);
    chk("rs_pre_sat", 32'(sat_flag), 1);
    rstb = 0;
    #1;
    chk("rs_rts", 32'(aud_out_rts), 0);
    chk("rs_aud", aud_out, 0);
    chk("rs_cnt", 32'(fifo_count), 0);
    chk("rs_flags", {30'd0, sat_flag, ovf_flag}, 0);
    tick();
    rstb = 1;
    aud_out_rtr = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("rs_post_rts", 32'(aud_out_rts), 0);
    chk("rs_post_cnt", 32'(fifo_count), 0);

    // random traffic against a behavioural scoreboard
    m_rts = 0; m_s1v = 0; m_s1s = 0; m_sat = 0; m_ovf = 0; m_out = 0; m_s1w = 0;
    for (int c = 0; c < 10000; c++) begin
      acc_done = ($urandom_range(0, 2) != 0);
      aud_out_rtr = ($urandom_range(0, 3) < 2);
      ovf_clear = ($urandom_range(0, 31) == 0);
      acc_data = {8'($urandom), $urandom};
      if ($urandom_range(0, 3) == 0) acc_data[39:36] = 4'h7;
      xfer = m_rts && aud_out_rtr;
      pop = q.size() != 0 && (!m_rts || xfer);
      push = m_s1v && (q.size() < 4 || pop);
      m_sat = (m_s1v && m_s1s) || (m_sat && !ovf_clear);
      m_ovf = (m_s1v && !push) || (m_ovf && !ovf_clear);
      if (pop) begin
        m_out = q.pop_front();
        m_rts = 1;
      end else if (xfer) m_rts = 0;
      if (push) q.push_back(m_s1w);
      ml = mdl(acc_data[39:20]);
      mr = mdl(acc_data[19:0]);
      m_s1v = acc_done;
      m_s1w = {ml[15:0], mr[15:0]};
      m_s1s = ml[16] | mr[16];
      tick();
      chk("rnd_rts", 32'(aud_out_rts), 32'(m_rts));
      chk("rnd_cnt", 32'(fifo_count), q.size());
      chk("rnd_flags", {30'd0, sat_flag, ovf_flag}, {30'd0, m_sat, m_ovf});
      if (m_rts) chk("rnd_word", aud_out, m_out);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
